// File: rtl/vga_rom_scheduler.sv
// rtl/vga_rom_scheduler.sv - VGA timing generator and single-port ROM read scheduler
// Display fetch inside the image window always wins the ROM port; the host gets idle cycles.
module vga_rom_scheduler #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int IMG_X0   = 100,
  parameter int IMG_Y0   = 100,
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 200,
  parameter int ADDR_W   = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk_25M,
  input  logic              reset,
  output logic [9:0]        h_count,
  output logic [9:0]        v_count,
  output logic              enable_V_Counter,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              win_on,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_PRE  = 10'(H_TOTAL - 2);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_BEG  = 10'(IMG_X0);
  localparam logic [9:0] X_END  = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0] Y_BEG  = 10'(IMG_Y0);
  localparam logic [9:0] Y_END  = 10'(IMG_Y0 + IMG_H);

  // Pipe word layout: {gnt, win, vid, vs, hs}; idle value has both syncs inactive-high.
  localparam logic [4:0] PIPE_IDLE = 5'b00011;

  logic              hs_raw;
  logic              vs_raw;
  logic              vid_raw;
  logic              win_raw;
  logic              gnt;
  logic [ADDR_W-1:0] pix_addr;
  logic [4:0]        pipe [ROM_LAT];

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      h_count          <= 10'd0;
      v_count          <= 10'd0;
      enable_V_Counter <= 1'b0;
    end else begin
      enable_V_Counter <= (h_count == H_PRE);
      if (h_count == H_LAST) begin
        h_count <= 10'd0;
        v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  always_comb begin
    hs_raw  = !((h_count >= HS_BEG) && (h_count < HS_END));
    vs_raw  = !((v_count >= VS_BEG) && (v_count < VS_END));
    vid_raw = (h_count < H_VIS) && (v_count < V_VIS);
    win_raw = (h_count >= X_BEG) && (h_count < X_END) &&
              (v_count >= Y_BEG) && (v_count < Y_END);
  end

  // Raster-order window pixels are consecutive, so a counter replaces (y-Y0)*W+(x-X0).
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      pix_addr <= '0;
    end else if ((h_count == H_LAST) && (v_count == V_LAST)) begin
      pix_addr <= '0;
    end else if (win_raw) begin
      pix_addr <= pix_addr + 1'b1;
    end
  end

  assign gnt      = reset & host_req & ~win_raw;
  assign host_gnt = gnt;
  assign rom_addr = gnt ? host_addr : pix_addr;

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= PIPE_IDLE;
    end else begin
      pipe[0] <= {gnt, win_raw, vid_raw, vs_raw, hs_raw};
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {host_rvalid, win_on, video_on, vsync, hsync} = pipe[ROM_LAT-1];

endmodule

// File: doc/vga_rom_scheduler.md
Name: vga_rom_scheduler

Overview:
- Master timing and ROM-access scheduler for the 640x480@60 Hz VGA path, running on the 25 MHz pixel clock.
- Runs the horizontal pixel counter and issues the per-line enable_V_Counter pulse that steps the vertical line counter.
- Generates hsync/vsync/video_on and the image-window flag, and computes the linear image-ROM address for the window.
- Arbitrates the single synchronous ROM read port between display fetch (absolute priority) and one host/loader requester.

Parameters:
H_TOTAL, 800, pixels per line
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
V_TOTAL, 525, lines per frame
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width in lines
IMG_X0, 100, first window column
IMG_Y0, 100, first window line
IMG_W, 200, window width in pixels
IMG_H, 200, window height in lines
ADDR_W, 16, ROM address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
- clk_25M  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- h_count  out  10  current column, 0..H_TOTAL-1
- v_count  out  10  current line, 0..V_TOTAL-1
- enable_V_Counter  out  1  one-cycle pulse on the last pixel of each line
- hsync  out  1  active-low, delayed to align with ROM data
- vsync  out  1  active-low, delayed to align with ROM data
- video_on  out  1  visible-area flag, delayed to align with ROM data
- win_on  out  1  pixel lies inside the image window, delayed to align with ROM data
- rom_addr  out  ADDR_W  ROM read address, combinational mux
- host_req  in  1  host read request; held until granted
- host_addr  in  ADDR_W  host read address; stable while host_req is high
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  ROM data belongs to the host, ROM_LAT cycles after host_gnt

Behaviour:
- Reset, asynchronous: h_count=0, v_count=0, enable_V_Counter=0, hsync=1, vsync=1, video_on=0, win_on=0, host_gnt=0, host_rvalid=0, pixel address counter=0.
- Reset mid-operation clears all delay-pipeline stages. Any in-flight host read is dropped and no host_rvalid is produced for it.
- h_count increments every cycle and wraps H_TOTAL-1 -> 0.
- enable_V_Counter = (h_count == H_TOTAL-1), registered-decode, so it is high exactly during that cycle.
- v_count increments when h_count wraps and wraps V_TOTAL-1 -> 0 on the same edge as h_count.
- Raw timing flags, all in the same cycle as the counters:
  - hs_raw low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - vid_raw = h < H_ACTIVE and v < V_ACTIVE.
  - win_raw = h in [IMG_X0, IMG_X0+IMG_W) and v in [IMG_Y0, IMG_Y0+IMG_H).
- hsync, vsync, video_on and win_on are the raw flags delayed by exactly ROM_LAT cycles through a shift pipeline. Their reset value matches the inactive level.
- Pixel address counter:
  - Reset to 0 on the cycle h_count=0, v_count=0.
  - Increments by 1 after every cycle with win_raw=1. No multiplier is used.
  - Pixel (x, y) inside the window maps to (y-IMG_Y0)*IMG_W + (x-IMG_X0).
  - Saturation is not needed: the counter reaches at most IMG_W*IMG_H-1 before frame reset.
- Arbitration, fixed priority, one ROM read per cycle:
  - win_raw=1: rom_addr = pixel address; host_gnt=0.
  - win_raw=0 and host_req=1: rom_addr = host_addr; host_gnt=1 in that same cycle.
  - Neither: rom_addr holds the pixel address; no grant.
- Host handshake:
  - The host keeps host_req and host_addr stable until it sees host_gnt.
  - Back-to-back requests outside the window are granted every cycle.
  - host_rvalid is host_gnt delayed ROM_LAT cycles.
  - A host request arriving at the window's last pixel is granted on the next cycle.

Test Plan:
- Release reset, run 800 cycles -> enable_V_Counter high only at h_count=799; v_count becomes 1 with h_count=0 on the following edge.
- Run a full frame -> v_count wraps 524 -> 0 at h_count wrap; with ROM_LAT=1, hsync low for h 657..752 (raw 656..751) and vsync low for lines 490..491 delayed one cycle.
- Window addressing -> rom_addr=0 at (100,100), 199 at (299,100), 200 at (100,101), 39999 at (299,299); win_on and video_on are high ROM_LAT cycles after each of these points.
- host_req=1, host_addr=0x1234 asserted at (150,150) -> host_gnt=0 through x=299; host_gnt=1 and rom_addr=0x1234 at x=300; host_rvalid=1 ROM_LAT cycles later.
- host_req held continuously during horizontal blanking -> one grant per cycle; host_rvalid stream matches the grants shifted by ROM_LAT.
- Assert reset at h=420, v=200 with a host read in flight -> all outputs take reset values immediately, no stray host_rvalid; after release, counting restarts from (0,0) and the address sequence is correct.
